// File: rtl/led_matrix_scanner.sv
// Double-buffered 6x6 LED frame receiver and row scanner with blanking between rows.
// Optional BRIGHTNESS_PWM_EN adds a 4-bit brightness input that gates column data by PWM.
module led_matrix_scanner #(
    parameter int unsigned ROWS  = 6,
    parameter int unsigned COLS  = 6,
    parameter int unsigned DWELL = 1000,
    parameter int unsigned BLANK = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ROWS*COLS-1:0]   leds,
    input  logic                   frame_valid,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [3:0]             brightness,
`endif
    output logic                   frame_ready,
    output logic [ROWS-1:0]        row_sel,
    output logic [COLS-1:0]        col_data,
    output logic                   frame_done
);

    localparam int unsigned Frame  = ROWS * COLS;
    localparam int unsigned CntMax = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned RowW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK - 1);
    localparam logic [RowW-1:0] RowLast   = RowW'(ROWS - 1);

    typedef enum logic {StBlank, StDrive} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [Frame-1:0] active_q, active_d;
    logic [Frame-1:0] pend_q, pend_d;
    logic             ready_q, ready_d;
    logic [ROWS-1:0]  row_sel_q, row_sel_d;
    logic [COLS-1:0]  col_data_q, col_data_d;
    logic             done_q, done_d;
    logic             accept;
    logic             end_of_frame;

`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] pwm_q, pwm_d;
    logic       pwm_on;
`endif

    assign accept = frame_valid && ready_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        row_d        = row_q;
        active_d     = active_q;
        pend_d       = pend_q;
        ready_d      = ready_q;
        end_of_frame = 1'b0;

        unique case (state_q)
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d = StDrive;
                    cnt_d   = '0;
                end
            end
            StDrive: begin
                if (cnt_q == DwellLast) begin
                    state_d      = StBlank;
                    cnt_d        = '0;
                    end_of_frame = (row_q == RowLast);
                    row_d        = (row_q == RowLast) ? '0 : row_q + 1'b1;
                end
            end
            default: ;
        endcase

        // Accept only into an empty pending buffer; swap only out of a full one.
        if (accept) begin
            pend_d  = leds;
            ready_d = 1'b0;
        end
        if (end_of_frame && !ready_q) begin
            active_d = pend_q;
            ready_d  = 1'b1;
        end
    end

`ifdef BRIGHTNESS_PWM_EN
    assign pwm_d  = pwm_q + 4'd1;
    assign pwm_on = (brightness == 4'hF) || (pwm_q < brightness);
`endif

    // Pin registers follow the state register by one cycle.
    always_comb begin
        row_sel_d  = '0;
        col_data_d = '0;
        done_d     = end_of_frame;
        if (state_q == StDrive) begin
            row_sel_d  = ROWS'(1) << row_q;
            col_data_d = active_q[32'(row_q) * COLS +: COLS];
`ifdef BRIGHTNESS_PWM_EN
            if (!pwm_on) begin
                col_data_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StBlank;
            cnt_q      <= '0;
            row_q      <= '0;
            active_q   <= '0;
            pend_q     <= '0;
            ready_q    <= 1'b1;
            row_sel_q  <= '0;
            col_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            ready_q    <= ready_d;
            row_sel_q  <= row_sel_d;
            col_data_q <= col_data_d;
            done_q     <= done_d;
        end
    end

`ifdef BRIGHTNESS_PWM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`endif

    assign frame_ready = ready_q;
    assign row_sel     = row_sel_q;
    assign col_data    = col_data_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed, frame-table-driven bench for led_matrix_scanner (ROWS=COLS=6, BLANK=2).
module tb_led_matrix_scanner;

    localparam int ROWS = 6;
    localparam int COLS = 6;
    localparam int BLK  = 2;
`ifdef BRIGHTNESS_PWM_EN
    localparam int DW   = 32;
`else
    localparam int DW   = 4;
`endif
    localparam int RowPer   = BLK + DW;
    localparam int FramePer = ROWS * RowPer;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [ROWS*COLS-1:0] leds;
    logic                 frame_valid;
    logic                 frame_ready;
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      col_data;
    logic                 frame_done;
`ifdef BRIGHTNESS_PWM_EN
    logic [3:0]           brightness;
`endif

    int checks   = 0;
    int failures = 0;

    led_matrix_scanner #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DWELL (DW),
        .BLANK (BLK)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .leds        (leds),
        .frame_valid (frame_valid),
`ifdef BRIGHTNESS_PWM_EN
        .brightness  (brightness),
`endif
        .frame_ready (frame_ready),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        send;
        logic [35:0] send_leds;
        logic        hold_en;
        logic [35:0] hold_leds;
        logic        late_en;
        logic [35:0] late_leds;
        logic [35:0] shown;
        logic        ready_mid;
        logic        ready_end;
    } frame_rec_t;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic run_frame(input int idx, input frame_rec_t r);
        logic [ROWS-1:0] exp_rs;
        logic [COLS-1:0] exp_cd;
        logic [35:0]     shown;
        int              rowp;
        frame_valid = r.send;
        if (r.send) leds = r.send_leds;
        shown = r.shown;
        for (int i = 0; i < FramePer; i++) begin
            step();
            if (i == 0) begin
                if (r.hold_en) leds = r.hold_leds;
                else frame_valid = 1'b0;
            end
            if (r.late_en && i == FramePer - 2) begin
                frame_valid = 1'b1;
                leds        = r.late_leds;
            end
            rowp   = i / RowPer;
            exp_rs = '0;
            exp_cd = '0;
            if ((i % RowPer) >= BLK) begin
                exp_rs = ROWS'(1) << rowp;
                exp_cd = shown[rowp*COLS +: COLS];
            end
            check($sformatf("frame%0d_cyc%0d_rs_cd_done", idx, i),
                  {51'd0, row_sel, col_data, frame_done},
                  {51'd0, exp_rs, exp_cd, (i == FramePer - 1)});
            if (i == FramePer / 2)
                check($sformatf("frame%0d_ready_mid", idx), 64'(frame_ready), 64'(r.ready_mid));
        end
        check($sformatf("frame%0d_ready_end", idx), 64'(frame_ready), 64'(r.ready_end));
    endtask

    localparam logic [35:0] Row0On = 36'h0_0000_003F;
    localparam logic [35:0] Border = {6'h3F, 6'h21, 6'h21, 6'h21, 6'h21, 6'h3F};
    localparam logic [35:0] FrameA = 36'h1_2345_6789;
    localparam logic [35:0] FrameB = 36'hA_5A5A_5A5A;
    localparam logic [35:0] FrameC = 36'h8_4210_8421;
    localparam logic [35:0] FrameD = 36'hF_FFFF_FFFF;

    frame_rec_t tbl[9];
    frame_rec_t idle0;

    initial begin
        // send, leds, hold, hold_leds, late, late_leds, shown, ready_mid, ready_end
        tbl[0] = '{1'b1, Row0On, 1'b0, '0,     1'b0, '0,     '0,     1'b0, 1'b1};
        tbl[1] = '{1'b1, Border, 1'b0, '0,     1'b0, '0,     Row0On, 1'b0, 1'b1};
        tbl[2] = '{1'b0, '0,     1'b0, '0,     1'b0, '0,     Border, 1'b1, 1'b1};
        tbl[3] = '{1'b0, '0,     1'b0, '0,     1'b0, '0,     Border, 1'b1, 1'b1};
        tbl[4] = '{1'b1, FrameA, 1'b1, FrameB, 1'b0, '0,     Border, 1'b0, 1'b1};
        tbl[5] = '{1'b1, FrameB, 1'b0, '0,     1'b0, '0,     FrameA, 1'b0, 1'b1};
        tbl[6] = '{1'b0, '0,     1'b0, '0,     1'b1, FrameC, FrameB, 1'b1, 1'b0};
        tbl[7] = '{1'b0, '0,     1'b0, '0,     1'b0, '0,     FrameB, 1'b0, 1'b1};
        tbl[8] = '{1'b0, '0,     1'b0, '0,     1'b0, '0,     FrameC, 1'b1, 1'b1};
        idle0  = '{1'b0, '0,     1'b0, '0,     1'b0, '0,     '0,     1'b1, 1'b1};

        reset       = 1'b1;
        frame_valid = 1'b0;
        leds        = '0;
`ifdef BRIGHTNESS_PWM_EN
        brightness  = 4'hF;
`endif
        repeat (3) step();
        check("reset_outputs", {50'd0, row_sel, col_data, frame_done, frame_ready},
              {50'd0, 6'd0, 6'd0, 1'b0, 1'b1});
        reset = 1'b0;

        for (int f = 0; f < 9; f++) run_frame(f, tbl[f]);

        // Reset while row 3 is driven with a frame sitting in pending.
        frame_valid = 1'b1;
        leds        = FrameD;
        step();
        frame_valid = 1'b0;
        repeat (3 * RowPer + BLK) step();
        check("pre_reset_row3", {58'd0, row_sel}, {58'd0, 6'b001000});
        check("pre_reset_ready", 64'(frame_ready), 64'd0);
        reset = 1'b1;
        step();
        check("midscan_reset_outputs", {50'd0, row_sel, col_data, frame_done, frame_ready},
              {50'd0, 6'd0, 6'd0, 1'b0, 1'b1});
        reset = 1'b0;
        run_frame(9, idle0);
        run_frame(10, idle0);

`ifdef BRIGHTNESS_PWM_EN
        begin
            frame_rec_t on_rec;
            int         lit;
            int         bvals[3];
            int         bexp[3];
            bvals = '{4, 15, 0};
            bexp  = '{48, 192, 0};
            on_rec = '{1'b1, FrameD, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1};
            run_frame(11, on_rec);
            for (int k = 0; k < 3; k++) begin
                brightness = 4'(bvals[k]);
                lit = 0;
                for (int i = 0; i < FramePer; i++) begin
                    step();
                    if (col_data != '0) lit++;
                end
                check($sformatf("pwm_b%0d_lit_cycles", bvals[k]), 64'(lit), 64'(bexp[k]));
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
